op_sequencer: RTL and testbench

Front-end sequencer upstream of the control unit (BC) and its datapath. Buffers operand requests in a small FIFO and launches one operation at a time: presents the operand on `x_out` and pulses the control unit's start input `w`. Waits for the control unit's `done`, captures the datapath result and offers it on a valid/ready output port. A watchdog aborts operations whose `done` never arrives.

---
 rtl/op_sequencer_if.sv | 32 +++
 rtl/op_sequencer.sv | 116 +++++++++++
 tb/tb_op_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/op_sequencer_if.sv
// Operand/result handshake bundle between the sequencer, its operand source,
// the control unit and the result consumer.
interface op_sequencer_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          w;
    logic [W-1:0]  x_out;
    logic          done;
    logic [W-1:0]  s_in;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          busy;
    logic          err;

    modport master (
        input  in_valid, in_data, done, s_in, out_ready,
        output in_ready, w, x_out, out_valid, out_data, level, busy, err
    );

    modport slave (
        output in_valid, in_data, done, s_in, out_ready,
        input  in_ready, w, x_out, out_valid, out_data, level, busy, err
    );
endinterface

// File: rtl/op_sequencer.sv
// Operand FIFO plus a one-at-a-time launcher for the control unit, with a
// valid/ready result slot and a RUN-state watchdog.
module op_sequencer #(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    op_sequencer_if.master bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    state_t                    state_q, state_d;
    logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
    logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [W-1:0]              x_q, x_d;
    logic                      out_valid_q, out_valid_d;
    logic [W-1:0]              out_data_q, out_data_d;
    logic                      err_q, err_d;
    logic [WD_W-1:0]           wdog_q, wdog_d;

    logic full, empty, push;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty = (wptr_q == rptr_q);
    assign push  = bus.in_valid && !full;

    assign bus.in_ready  = !full;
    assign bus.w         = (state_q == START);
    assign bus.busy      = (state_q != IDLE);
    assign bus.x_out     = x_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.err       = err_q;
    assign bus.level     = wptr_q - rptr_q;

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        x_d         = x_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        wdog_d      = wdog_q;

        if (push) begin
            mem_d[wptr_q[AW-1:0]] = bus.in_data;
            wptr_d                = wptr_q + PW'(1);
        end

        if (out_valid_q && bus.out_ready)
            out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Pop decision uses registered pointers, so a fresh push
                // cannot bypass straight to x_out in the same cycle.
                if (!empty && !out_valid_q) begin
                    state_d = START;
                    x_d     = mem_q[rptr_q[AW-1:0]];
                    rptr_d  = rptr_q + PW'(1);
                end
            end
            START: begin
                state_d = RUN;
                wdog_d  = '0;
            end
            RUN: begin
                if (bus.done) begin
                    state_d     = IDLE;
                    out_data_d  = bus.s_in;
                    out_valid_d = 1'b1;
                end else if (wdog_q == WD_MAX) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
        end
    end
endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: a modelled control unit answers each w
// pulse with done after a set latency and s_in = operand * 5.
module tb_op_sequencer;
    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    op_sequencer_if #(.W(W), .DEPTH(DEPTH)) bus ();

    op_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Control-unit model
    bit          resp_en  = 1'b1;
    int          resp_lat = 3;
    int          pending  = 0;
    logic [W-1:0] cap;

    always @(negedge clk) begin
        if (rst) begin
            pending  = 0;
            bus.done = 1'b0;
            bus.s_in = '0;
        end else begin
            bus.done = 1'b0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    bus.done = resp_en;
                    bus.s_in = cap * 8'd5;
                end
            end
            if (bus.w) begin
                pending = resp_lat;
                cap     = bus.x_out;
            end
        end
    end

    // Monitor: w pulses, consumed results, peak occupancy
    int unsigned  w_cnt = 0;
    int unsigned  max_level = 0;
    logic [W-1:0] got_q[$];

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (bus.w) w_cnt++;
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
            if (int'(bus.level) > max_level) max_level = int'(bus.level);
        end
    end

    task automatic push(input logic [W-1:0] d);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("push_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_results(input int unsigned target, input string tag);
        int n;
        n = 0;
        while (got_q.size() < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, got_q.size(), target);
    endtask

    initial begin
        int unsigned  b, wc, n;
        logic [W-1:0] hold;
        bit           stable;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  bus.in_ready, 1);
        chk("rst_w",         bus.w, 0);
        chk("rst_level",     bus.level, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy",      bus.busy, 0);
        chk("rst_err",       bus.err, 0);
        chk("rst_x_out",     bus.x_out, 0);
        chk("rst_out_data",  bus.out_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single operation with launch latency
        resp_lat = 3;
        push(8'h05);
        chk("lat_level_n",   bus.level, 1);
        chk("lat_w_n",       bus.w, 0);
        @(negedge clk);
        chk("lat_w_n1",      bus.w, 1);
        chk("lat_x_out",     bus.x_out, 8'h05);
        chk("lat_level_n1",  bus.level, 0);
        @(negedge clk);
        chk("lat_w_n2",      bus.w, 0);
        chk("lat_busy_run",  bus.busy, 1);
        n = 0;
        while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
        chk("single_out_valid", bus.out_valid, 1);
        chk("single_out_data",  bus.out_data, 8'h19);
        chk("single_w_cnt",     w_cnt, 1);
        chk("single_busy",      bus.busy, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("single_consumed",  bus.out_valid, 0);

        // FIFO full, back-pressure and ordering
        resp_lat = 1;
        b = got_q.size();
        for (int i = 1; i <= 5; i++) push(8'(i));
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_level",    bus.level, 4);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h06;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("full_level_hold", bus.level, 4);
        chk("bp_out_valid",    bus.out_valid, 1);
        wc     = w_cnt;
        hold   = bus.out_data;
        stable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_data !== hold) stable = 1'b0;
        end
        chk("bp_no_launch",   w_cnt, wc);
        chk("bp_data_stable", stable, 1);
        chk("bp_out_data",    hold, 8'h05);
        bus.out_ready = 1'b1;
        wait_results(b + 5, "drain_count");
        for (int i = 0; i < 5; i++)
            if (b + i < got_q.size()) chk("drain_order", got_q[b+i], 8'(5 * (i + 1)));

        // Timeout: first operand never gets done, second still launches
        resp_en = 1'b0;
        b = got_q.size();
        push(8'h07);
        push(8'h08);
        n = 0;
        while (!bus.w && n < 20) begin @(negedge clk); n++; end
        chk("to_w_seen", bus.w, 1);
        @(negedge clk);
        n = 0;
        while (!bus.err && n < 200) begin
            if (bus.busy) n++;
            @(negedge clk);
        end
        chk("to_run_cycles", n, TIMEOUT);
        chk("to_err",        bus.err, 1);
        chk("to_out_valid",  bus.out_valid, 0);
        chk("to_busy",       bus.busy, 0);
        resp_en = 1'b1;
        wait_results(b + 1, "to_next_launch");
        if (b < got_q.size()) chk("to_next_data", got_q[b], 8'h28);
        chk("to_err_sticky", bus.err, 1);

        // Continuous streaming across pointer wraps
        max_level = 0;
        b = got_q.size();
        for (int i = 0; i < 20; i++) push(8'(8'h10 + i));
        wait_results(b + 20, "stream_count");
        for (int i = 0; i < 20; i++)
            if (b + i < got_q.size()) chk("stream_order", got_q[b+i], 8'((8'h10 + i) * 5));
        chk("stream_max_level", max_level <= DEPTH, 1);

        // Reset during RUN with two operands queued
        resp_en = 1'b0;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        chk("mid_pre_level", bus.level, 2);
        chk("mid_pre_run",   bus.busy && !bus.w, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_w",         bus.w, 0);
        chk("mid_out_valid", bus.out_valid, 0);
        chk("mid_level",     bus.level, 0);
        chk("mid_busy",      bus.busy, 0);
        chk("mid_err",       bus.err, 0);
        wc = w_cnt;
        b  = got_q.size();
        @(negedge clk);
        rst     = 1'b0;
        resp_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_no_launch", w_cnt, wc);
        chk("mid_no_result", got_q.size(), b);
        chk("mid_level_post", bus.level, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
